data_memory_sync: RTL and testbench
===================================

DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter XLEN, default 32: data width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4096: storage size in bytes; power of two, at least 8.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port read_enable, input, 1: load request this cycle.
REQ-006 Port read_addr, input, XLEN: load byte address.
REQ-007 Port read_funct3, input, 3: load size and sign (RISC-V LB/LH/LW/LD/LBU/LHU/LWU encoding).
REQ-008 Port write_enable, input, 1: store request this cycle.
REQ-009 Port write_addr, input, XLEN: store byte address.
REQ-010 Port write_funct3, input, 3: store size (SB/SH/SW/SD encoding).
REQ-011 Port write_data, input, XLEN: store data; low bytes used per size.
REQ-012 Port read_data, output, XLEN: extended load result, registered.
REQ-013 Port read_valid, output, 1: read_data valid this cycle.
REQ-014 Port access_error, output, 1: one-cycle pulse flagging a rejected load or store.

Function
REQ-015 Storage SHALL be DEPTH bytes, little-endian; effective byte index = (addr + i) mod DEPTH, so multi-byte accesses wrap from DEPTH-1 to 0.
REQ-016 Store SHALL commit on the rising edge where write_enable=1: 1 byte (000), 2 (001), 4 (010), 8 (011, XLEN=64 only); other bytes are unchanged.
REQ-017 Load SHALL be sampled on the rising edge where read_enable=1; read_data and read_valid=1 SHALL appear on the next cycle (latency 1); read_valid SHALL be 0 in every cycle not following an accepted load.
REQ-018 Load extension: 000/001/010 sign-extend to XLEN; 100/101/110 zero-extend; 011 returns 8 bytes (XLEN=64 only).
REQ-019 Illegal funct3 (store 1xx; load 111; 011 or 110 when XLEN=32) SHALL suppress the access and pulse access_error one cycle later; a rejected load SHALL give read_valid=1 with read_data=0.
REQ-020 Simultaneous load and store in one cycle SHALL be write-first: each overlapping byte of the load returns the newly stored byte; non-overlapping bytes return prior contents.
REQ-021 Back-to-back loads, one per cycle, SHALL be supported with throughput 1 and no bubbles.
REQ-022 read_data SHALL hold its last value while read_valid=0.
REQ-023 If a load and a store are both rejected in one cycle, access_error SHALL be a single pulse.

Reset
REQ-024 While rst=1 at a rising edge: read_data<=0, read_valid<=0, access_error<=0; loads and stores presented that cycle SHALL be ignored.
REQ-025 A load accepted in the cycle before rst is asserted SHALL be discarded (read_valid=0 in the rst cycle output).
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: any access not naturally aligned (half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0) SHALL be suppressed and pulse access_error per REQ-019 rules.
REQ-028 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL be performed byte-wise per REQ-015 including wrap; access_error only for illegal funct3.

Verification
REQ-029 Reset then SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> one cycle later read_valid=1, read_data=0xDEADBEEF.
REQ-030 After REQ-029: LB @0x10 -> 0xFFFFFFEF; LBU @0x10 -> 0x000000EF; LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD.
REQ-031 Same cycle SB 0x55 @0x11 and LW @0x10 (memory 0xDEADBEEF) -> read_data=0xDEAD55EF; next LW @0x10 -> 0xDEAD55EF.
REQ-032 SW 0x11223344 @DEPTH-2: with macro -> access_error pulse, memory unchanged; without -> bytes 0x44,0x33 at DEPTH-2/DEPTH-1, 0x22,0x11 at 0/1, LW @DEPTH-2 returns 0x11223344.
REQ-033 Load funct3=111 @0x0 -> read_valid=1, read_data=0, access_error=1 for exactly one cycle.
REQ-034 LW @0x10 accepted, rst=1 next cycle -> read_valid=0 throughout; after reset LW @0x10 still returns prior contents.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// data_memory_sync_if: load/store request bus for data_memory_sync.
// master drives requests, slave returns the registered load result.
interface data_memory_sync_if #(
  parameter int XLEN = 32
);
  logic            read_enable;
  logic [XLEN-1:0] read_addr;
  logic [2:0]      read_funct3;
  logic            write_enable;
  logic [XLEN-1:0] write_addr;
  logic [2:0]      write_funct3;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] read_data;
  logic            read_valid;
  logic            access_error;

  modport master (
    output read_enable,
    output read_addr,
    output read_funct3,
    output write_enable,
    output write_addr,
    output write_funct3,
    output write_data,
    input  read_data,
    input  read_valid,
    input  access_error
  );

  modport slave (
    input  read_enable,
    input  read_addr,
    input  read_funct3,
    input  write_enable,
    input  write_addr,
    input  write_funct3,
    input  write_data,
    output read_data,
    output read_valid,
    output access_error
  );
endinterface

// File: rtl/data_memory_sync.sv
// data_memory_sync: byte-addressed little-endian data memory, 1-cycle loads.
// Define DMEM_MISALIGN_TRAP_EN to reject naturally misaligned accesses.
module data_memory_sync #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4096
) (
  input logic               clk,
  input logic               rst,
  data_memory_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic IS64 = (XLEN == 64);

  logic [7:0]      mem [DEPTH];

  logic            wr_legal;
  logic            rd_legal;
  logic            wr_ok;
  logic            rd_ok;
  logic            wr_fire;
  logic [3:0]      wr_bytes;
  logic [AW-1:0]   wbase;
  logic [AW-1:0]   rbase;
  logic [AW-1:0]   ridx;
  logic [AW-1:0]   woff;
  logic [63:0]     wd64;
  logic [63:0]     raw;
  logic [63:0]     ext64;
  logic [XLEN-1:0] rd_result;

  logic [XLEN-1:0] rdata_q;
  logic            rvalid_q;
  logic            err_q;
  logic            unused_bits;

  function automatic logic [3:0] size_of(input logic [1:0] f);
    logic [3:0] s;
    case (f)
      2'b00:   s = 4'd1;
      2'b01:   s = 4'd2;
      2'b10:   s = 4'd4;
      default: s = 4'd8;
    endcase
    return s;
  endfunction

  function automatic logic aligned(
    input logic [1:0] f,
    input logic [2:0] a
  );
    logic ok;
    case (f)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a[1:0] == 2'b00);
      default: ok = (a == 3'b000);
    endcase
    return ok;
  endfunction

  assign wbase = bus.write_addr[AW-1:0];
  assign rbase = bus.read_addr[AW-1:0];
  assign wd64  = 64'(bus.write_data);
  assign wr_bytes = size_of(bus.write_funct3[1:0]);

  // Which funct3 encodings exist for this XLEN.
  always_comb begin
    wr_legal = 1'b0;
    rd_legal = 1'b0;
    case (bus.write_funct3)
      3'b000, 3'b001, 3'b010: wr_legal = 1'b1;
      3'b011:                 wr_legal = IS64;
      default:                wr_legal = 1'b0;
    endcase
    case (bus.read_funct3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101:         rd_legal = 1'b1;
      3'b011, 3'b110:         rd_legal = IS64;
      default:                rd_legal = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign wr_ok = wr_legal &
    aligned(bus.write_funct3[1:0], bus.write_addr[2:0]);
  assign rd_ok = rd_legal &
    aligned(bus.read_funct3[1:0], bus.read_addr[2:0]);
`else
  assign wr_ok = wr_legal;
  assign rd_ok = rd_legal;
`endif

  assign wr_fire = bus.write_enable & wr_ok & ~rst;

  // Gather load bytes; bytes hit by a same-cycle store come from write_data.
  always_comb begin
    raw  = '0;
    ridx = '0;
    woff = '0;
    for (int i = 0; i < NB; i++) begin
      ridx = rbase + AW'(i);
      woff = ridx - wbase;
      if (wr_fire && (int'(woff) < int'(wr_bytes))) begin
        raw[8*i +: 8] = wd64[{woff[2:0], 3'b000} +: 8];
      end else begin
        raw[8*i +: 8] = mem[ridx];
      end
    end
  end

  // Size and sign/zero extension of the gathered bytes.
  always_comb begin
    ext64 = '0;
    case (bus.read_funct3)
      3'b000:  ext64 = {{56{raw[7]}}, raw[7:0]};
      3'b001:  ext64 = {{48{raw[15]}}, raw[15:0]};
      3'b010:  ext64 = {{32{raw[31]}}, raw[31:0]};
      3'b011:  ext64 = raw;
      3'b100:  ext64 = {56'd0, raw[7:0]};
      3'b101:  ext64 = {48'd0, raw[15:0]};
      3'b110:  ext64 = {32'd0, raw[31:0]};
      default: ext64 = '0;
    endcase
  end

  assign rd_result = ext64[XLEN-1:0];

  // Commit stores byte by byte, wrapping at the top of storage.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (i < int'(wr_bytes)) begin
          mem[wbase + AW'(i)] <= wd64[8*i +: 8];
        end
      end
    end
  end

  // Registered load result, valid flag and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.read_enable;
      if (bus.read_enable) begin
        rdata_q <= rd_ok ? rd_result : '0;
      end
      err_q <= (bus.read_enable & ~rd_ok) |
               (bus.write_enable & ~wr_ok);
    end
  end

  assign bus.read_data    = rdata_q;
  assign bus.read_valid   = rvalid_q;
  assign bus.access_error = err_q;

  assign unused_bits = ^{bus.read_addr, bus.write_addr, ext64};
endmodule

// File: tb/tb_data_memory_sync.sv
// tb_data_memory_sync: directed + random checks against a byte-array model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design build.
module tb_data_memory_sync;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_memory_sync_if #(.XLEN(XLEN)) bus ();

  data_memory_sync #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  model [DEPTH];
  logic [63:0] exp_d = '0;
  logic        exp_v = 1'b0;
  logic        exp_e = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int wsize(input logic [2:0] f);
    case (f)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return (XLEN == 64) ? 8 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int rsize(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      3'd3:       return (XLEN == 64) ? 8 : 0;
      3'd6:       return (XLEN == 64) ? 4 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic bit misal(input longint unsigned a, input int sz);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (a % longint'(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] load_val(
    input longint unsigned a,
    input logic [2:0] f,
    input int sz
  );
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < sz; i++)
      v = v | (64'(model[(a + longint'(i)) % DEPTH]) << (8 * i));
    if (!f[2] && sz < 8 && v[8*sz-1])
      v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    if (XLEN == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input bit            r,
    input bit            re,
    input [XLEN-1:0]     ra,
    input [2:0]          rf,
    input bit            we,
    input [XLEN-1:0]     wa,
    input [2:0]          wf,
    input [XLEN-1:0]     wd
  );
    int ws;
    int rs;
    bit wok;
    bit rok;
    longint unsigned wd_l;
    rst              = r;
    bus.read_enable  = re;
    bus.read_addr    = ra;
    bus.read_funct3  = rf;
    bus.write_enable = we;
    bus.write_addr   = wa;
    bus.write_funct3 = wf;
    bus.write_data   = wd;
    if (r) begin
      exp_v = 1'b0;
      exp_d = '0;
      exp_e = 1'b0;
    end else begin
      ws   = wsize(wf);
      rs   = rsize(rf);
      wok  = we && ws != 0 && !misal(longint'(wa), ws);
      rok  = re && rs != 0 && !misal(longint'(ra), rs);
      wd_l = longint'(wd);
      if (wok)
        for (int i = 0; i < ws; i++)
          model[(longint'(wa) + longint'(i)) % DEPTH] = 8'(wd_l >> (8 * i));
      exp_e = (re && !rok) || (we && !wok);
      exp_v = re;
      if (re) exp_d = rok ? load_val(longint'(ra), rf, rs) : '0;
    end
    @(posedge clk);
    #1;
    chk("read_valid", 64'(bus.read_valid), 64'(exp_v));
    chk("access_error", 64'(bus.access_error), 64'(exp_e));
    chk("read_data", 64'(bus.read_data), exp_d);
  endtask

  task automatic idle();
    step(0, 0, '0, 3'd0, 0, '0, 3'd0, '0);
  endtask

  task automatic load(input [XLEN-1:0] a, input [2:0] f);
    step(0, 1, a, f, 0, '0, 3'd0, '0);
  endtask

  task automatic store(input [XLEN-1:0] a, input [2:0] f, input [XLEN-1:0] d);
    step(0, 0, '0, 3'd0, 1, a, f, d);
  endtask

  function automatic logic [XLEN-1:0] raddr(input int mode);
    case (mode)
      0:       return XLEN'($urandom_range(0, 31));
      1:       return XLEN'($urandom_range(DEPTH - 8, DEPTH - 1));
      default: return XLEN'($urandom);
    endcase
  endfunction

  initial begin
    int mode;
    rst = 1'b1;
    bus.read_enable  = 1'b0;
    bus.read_addr    = '0;
    bus.read_funct3  = '0;
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.write_funct3 = '0;
    bus.write_data   = '0;
    @(posedge clk);
    #1;

    // reset state, with a load and store presented that must be ignored
    step(1, 0, '0, 3'd0, 0, '0, 3'd0, '0);
    step(1, 1, 'h10, 3'd2, 1, 'h10, 3'd2, 'h1234_5678);

    // fill storage so every byte is known to the model
    for (int a = 0; a < DEPTH; a += 4)
      store(XLEN'(a), 3'd2, XLEN'($urandom));

    // basic SW / LW
    store('h10, 3'd2, 'hDEAD_BEEF);
    load('h10, 3'd2);
    chk("lw_basic", 64'(bus.read_data), 64'hDEAD_BEEF);

    load('h10, 3'd0);
    chk("lb", 64'(bus.read_data), 64'hFFFF_FFEF);
    load('h10, 3'd4);
    chk("lbu", 64'(bus.read_data), 64'h0000_00EF);
    load('h12, 3'd1);
    chk("lh", 64'(bus.read_data), 64'hFFFF_DEAD);
    load('h12, 3'd5);
    chk("lhu", 64'(bus.read_data), 64'h0000_DEAD);
    idle();
    chk("hold_data", 64'(bus.read_data), 64'h0000_DEAD);

    // write-first forwarding
    step(0, 1, 'h10, 3'd2, 1, 'h11, 3'd0, 'h55);
    chk("fwd_lw", 64'(bus.read_data), 64'hDEAD_55EF);
    load('h10, 3'd2);
    chk("fwd_after", 64'(bus.read_data), 64'hDEAD_55EF);

    // wrapping store at the top of storage
    store(XLEN'(DEPTH - 2), 3'd2, 'h1122_3344);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("wrap_trap_err", 64'(bus.access_error), 64'd1);
`else
    chk("wrap_err", 64'(bus.access_error), 64'd0);
`endif
    load(XLEN'(DEPTH - 2), 3'd2);
`ifndef DMEM_MISALIGN_TRAP_EN
    chk("wrap_lw", 64'(bus.read_data), 64'h1122_3344);
`endif
    load(XLEN'(DEPTH - 1), 3'd4);
    load('h0, 3'd4);
    load('h1, 3'd4);
`ifndef DMEM_MISALIGN_TRAP_EN
    chk("wrap_b1", 64'(bus.read_data), 64'h11);
`endif

    // illegal load funct3
    load('h0, 3'd7);
    chk("ill_valid", 64'(bus.read_valid), 64'd1);
    chk("ill_data", 64'(bus.read_data), 64'd0);
    chk("ill_err", 64'(bus.access_error), 64'd1);
    idle();
    chk("ill_err_clear", 64'(bus.access_error), 64'd0);

    // load and store both rejected: single pulse
    step(0, 1, 'h20, 3'd7, 1, 'h20, 3'd4, 'hFFFF_FFFF);
    idle();
    step(0, 0, '0, 3'd0, 1, 'h20, 3'd6, 'h0);

    // reset right after an accepted load
    load('h10, 3'd2);
    step(1, 1, 'h10, 3'd2, 0, '0, 3'd0, '0);
    step(1, 0, '0, 3'd0, 0, '0, 3'd0, '0);
    idle();
    load('h10, 3'd2);
    chk("post_rst_lw", 64'(bus.read_data), 64'hDEAD_55EF);

    // back-to-back loads
    for (int i = 0; i < 8; i++)
      load(XLEN'(4 * i), 3'(i % 3));

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      mode = $urandom_range(0, 2);
      step(($urandom_range(0, 49) == 0),
           1'($urandom), raddr(mode), 3'($urandom),
           1'($urandom), raddr(mode), 3'($urandom),
           XLEN'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
